// File: rtl/arp_pkg.sv
// Shared constants and types for the GMII receive-side ARP parser.
// Byte offsets count from the first destination-MAC byte after the SFD.
package arp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH_HDR,
    ST_ARP_BODY,
    ST_TAIL,
    ST_DROP
  } arp_state_e;

  localparam int unsigned CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD            = 8'hD5;
  localparam logic [7:0]  BCAST_BYTE     = 8'hFF;
  localparam logic [2:0]  PREAMBLE_MAX   = 3'd7;

  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REF   = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

  localparam cnt_t ETH_MIN_BYTES = 11'd64;

  localparam cnt_t OFF_DST     = 11'd0;
  localparam cnt_t OFF_SRC     = 11'd6;
  localparam cnt_t OFF_TYPE    = 11'd12;
  localparam cnt_t OFF_HTYPE   = 11'd14;
  localparam cnt_t OFF_PTYPE   = 11'd16;
  localparam cnt_t OFF_HLEN    = 11'd18;
  localparam cnt_t OFF_PLEN    = 11'd19;
  localparam cnt_t OFF_OPER    = 11'd20;
  localparam cnt_t OFF_SHA     = 11'd22;
  localparam cnt_t OFF_SPA     = 11'd28;
  localparam cnt_t OFF_THA     = 11'd32;
  localparam cnt_t OFF_TPA     = 11'd38;
  localparam cnt_t OFF_ARP_END = 11'd41;

  // Big-endian byte of a 16-bit field: even offset is the high byte.
  function automatic logic [7:0] be_byte16(input logic [15:0] v, input logic lo);
    return lo ? v[7:0] : v[15:8];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 (Ethernet FCS) with its state register.
// Shared between the GMII receive and transmit paths.
module crc32_d8
  import arp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = {1'b0, r[31:1]} ^ CRC_POLY_REF;
      else             r = {1'b0, r[31:1]};
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (clear_i)       crc_d = CRC_INIT;
    else if (enable_i) crc_d = crc_next(crc_q, data_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/arp_recv.sv
// GMII receive-side ARP parser: validates framing, header, ARP body, length
// and FCS, then strobes the sender MAC/IP and opcode of frames for local_ip.
module arp_recv
  import arp_pkg::*;
#(
  parameter int CHECK_FCS = 1,
  parameter int MAX_BYTES = 1518
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rx_data,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  output logic        arp_valid,
  output logic [15:0] arp_opcode,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic        arp_err
);

  localparam cnt_t MAX_CNT = cnt_t'((MAX_BYTES > 2047) ? 2047 : MAX_BYTES);

  logic       dv_q, dv_prev_q, er_q;
  logic [7:0] data_q;

  arp_state_e  state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  cnt_t        byte_cnt_q, byte_cnt_d;
  logic        bcast_q, bcast_d, ucast_q, ucast_d;
  logic        er_seen_q, er_seen_d;
  logic [15:0] oper_q, oper_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic        pass_q, pass_d, fail_q, fail_d;

  logic        valid_q, valid_d, err_q, err_d;
  logic [15:0] opcode_q, opcode_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d;

  logic        crc_clr, crc_en, crc_ok;
  logic [31:0] crc_q;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;
  logic [1:0]  tpa_idx;
  cnt_t        byte_inc;
  logic        mismatch, frame_ok;

  crc32_d8 u_crc (
    .clk_i    (gmii_clk),
    .rst_i    (rst),
    .clear_i  (crc_clr),
    .enable_i (crc_en),
    .data_i   (data_q),
    .crc_o    (crc_q)
  );

  // dv history resets high so a frame already on the wire is not mistaken for a start.
  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      dv_q      <= 1'b1;
      dv_prev_q <= 1'b1;
      er_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      dv_q      <= gmii_rx_dv;
      dv_prev_q <= dv_q;
      er_q      <= gmii_rx_er;
      data_q    <= gmii_rx_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    bcast_d    = bcast_q;
    ucast_d    = ucast_q;
    er_seen_d  = er_seen_q;
    oper_d     = oper_q;
    sha_d      = sha_q;
    spa_d      = spa_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    mismatch   = 1'b0;
    frame_ok   = 1'b0;
    mac_sh     = local_mac << {byte_cnt_q[2:0], 3'b000};
    tpa_idx    = byte_cnt_q[1:0] - 2'd2;
    ip_sh      = local_ip << {tpa_idx, 3'b000};
    byte_inc   = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 1'b1;
    crc_ok     = (crc_q == CRC_RESIDUE) || (CHECK_FCS == 0);

    case (state_q)
      ST_IDLE: begin
        if (dv_q && !dv_prev_q) begin
          if (!er_q && data_q == PREAMBLE_BYTE) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (er_q) begin
          state_d = ST_DROP;
        end else if (data_q == PREAMBLE_BYTE) begin
          if (pre_cnt_q == PREAMBLE_MAX) state_d = ST_DROP;
          else                           pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (data_q == SFD) begin
          state_d    = ST_ETH_HDR;
          byte_cnt_d = '0;
          crc_clr    = 1'b1;
          bcast_d    = 1'b1;
          ucast_d    = 1'b1;
          er_seen_d  = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_ETH_HDR: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (er_q || byte_cnt_q >= MAX_CNT) begin
          state_d = ST_DROP;
        end else begin
          crc_en     = 1'b1;
          byte_cnt_d = byte_inc;
          // Broadcast and unicast matches are tracked in parallel; drop once both fail.
          if (byte_cnt_q < OFF_SRC) begin
            bcast_d  = bcast_q && (data_q == BCAST_BYTE);
            ucast_d  = ucast_q && (data_q == mac_sh[47:40]);
            mismatch = !(bcast_d || ucast_d);
          end else if (byte_cnt_q >= OFF_TYPE) begin
            mismatch = data_q != be_byte16(ETH_TYPE_ARP, byte_cnt_q[0]);
          end
          if (mismatch)                               state_d = ST_DROP;
          else if (byte_cnt_q == OFF_HTYPE - 11'd1)   state_d = ST_ARP_BODY;
        end
      end

      ST_ARP_BODY: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (er_q || byte_cnt_q >= MAX_CNT) begin
          state_d = ST_DROP;
        end else begin
          crc_en     = 1'b1;
          byte_cnt_d = byte_inc;
          if (byte_cnt_q < OFF_PTYPE) begin
            mismatch = data_q != be_byte16(ARP_HTYPE_ETH, byte_cnt_q[0]);
          end else if (byte_cnt_q < OFF_HLEN) begin
            mismatch = data_q != be_byte16(ARP_PTYPE_IPV4, byte_cnt_q[0]);
          end else if (byte_cnt_q == OFF_HLEN) begin
            mismatch = data_q != ARP_HLEN_ETH;
          end else if (byte_cnt_q == OFF_PLEN) begin
            mismatch = data_q != ARP_PLEN_IPV4;
          end else if (byte_cnt_q < OFF_SHA) begin
            oper_d = {oper_q[7:0], data_q};
            if (byte_cnt_q == OFF_OPER) mismatch = data_q != ARP_OP_REQ[15:8];
            else mismatch = !(data_q == ARP_OP_REQ[7:0] || data_q == ARP_OP_REPLY[7:0]);
          end else if (byte_cnt_q < OFF_SPA) begin
            sha_d = {sha_q[39:0], data_q};
          end else if (byte_cnt_q < OFF_THA) begin
            spa_d = {spa_q[23:0], data_q};
          end else if (byte_cnt_q >= OFF_TPA) begin
            mismatch = data_q != ip_sh[31:24];
          end
          if (mismatch)                         state_d = ST_DROP;
          else if (byte_cnt_q == OFF_ARP_END)   state_d = ST_TAIL;
        end
      end

      ST_TAIL: begin
        if (!dv_q) begin
          frame_ok = (byte_cnt_q >= ETH_MIN_BYTES) && crc_ok && !er_seen_q;
          pass_d   = frame_ok;
          fail_d   = !frame_ok;
          state_d  = ST_IDLE;
        end else if (byte_cnt_q >= MAX_CNT) begin
          state_d = ST_DROP;
        end else begin
          crc_en     = 1'b1;
          byte_cnt_d = byte_inc;
          if (er_q) er_seen_d = 1'b1;
        end
      end

      ST_DROP: begin
        if (!dv_q) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Verdict is registered once, then published; this gives the fixed two-cycle strobe latency.
  always_comb begin
    valid_d   = pass_q;
    err_d     = fail_q;
    opcode_d  = pass_q ? oper_q : opcode_q;
    src_mac_d = pass_q ? sha_q  : src_mac_q;
    src_ip_d  = pass_q ? spa_q  : src_ip_q;
  end

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      bcast_q    <= 1'b0;
      ucast_q    <= 1'b0;
      er_seen_q  <= 1'b0;
      oper_q     <= '0;
      sha_q      <= '0;
      spa_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      opcode_q   <= '0;
      src_mac_q  <= '0;
      src_ip_q   <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      bcast_q    <= bcast_d;
      ucast_q    <= ucast_d;
      er_seen_q  <= er_seen_d;
      oper_q     <= oper_d;
      sha_q      <= sha_d;
      spa_q      <= spa_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      opcode_q   <= opcode_d;
      src_mac_q  <= src_mac_d;
      src_ip_q   <= src_ip_d;
    end
  end

  assign arp_valid   = valid_q;
  assign arp_err     = err_q;
  assign arp_opcode  = opcode_q;
  assign arp_src_mac = src_mac_q;
  assign arp_src_ip  = src_ip_q;

endmodule

// File: tb/tb_arp_recv.sv
// Directed bench for arp_recv: one instance with FCS checking and full length,
// one with FCS ignored and a 64-byte length limit, driven by the same GMII stream.
module tb_arp_recv;

  logic        clk = 1'b0;
  logic        rst, dv, er;
  logic [7:0]  data;
  logic [47:0] local_mac;
  logic [31:0] local_ip;

  logic        a_valid, a_err, b_valid, b_err;
  logic [15:0] a_op, b_op;
  logic [47:0] a_mac, b_mac;
  logic [31:0] a_ip, b_ip;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] frm[$];

  always #4 clk = ~clk;

  arp_recv #(.CHECK_FCS(1), .MAX_BYTES(1518)) dut (
    .gmii_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rx_data(data),
    .local_mac(local_mac), .local_ip(local_ip),
    .arp_valid(a_valid), .arp_opcode(a_op), .arp_src_mac(a_mac), .arp_src_ip(a_ip),
    .arp_err(a_err)
  );

  arp_recv #(.CHECK_FCS(0), .MAX_BYTES(64)) dut_nf (
    .gmii_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rx_data(data),
    .local_mac(local_mac), .local_ip(local_ip),
    .arp_valid(b_valid), .arp_opcode(b_op), .arp_src_mac(b_mac), .arp_src_ip(b_ip),
    .arp_err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_field(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[i*8 +: 8]);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                       input int pad_n, input bit bad_fcs);
    logic [31:0] c;
    frm.delete();
    push_field(dst, 6);
    push_field(48'h02_00_00_00_00_99, 6);
    push_field({32'h0, etype}, 2);
    push_field(48'h0001_0800_0604, 6);
    push_field({32'h0, oper}, 2);
    push_field(sha, 6);
    push_field({16'h0, spa}, 4);
    push_field(48'h0, 6);
    push_field({16'h0, tpa}, 4);
    for (int i = 0; i < pad_n; i++) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    push_field({16'h0, c[7:0], c[15:8], c[23:16], c[31:24]}, 4);
    if (bad_fcs) frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'hFF;
  endtask

  task automatic send(input int pre_n, input int er_idx, input int rst_idx);
    for (int i = 0; i < pre_n; i++) begin
      @(negedge clk); dv = 1'b1; er = 1'b0; data = 8'h55;
    end
    @(negedge clk); dv = 1'b1; data = 8'hD5;
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      data = frm[i];
      er   = (i == er_idx);
      rst  = (i == rst_idx);
    end
    @(negedge clk); dv = 1'b0; er = 1'b0; data = 8'h00; rst = 1'b0;
  endtask

  // Counts strobes on both instances over ncyc idle cycles after the frame ends.
  task automatic obs(input string tag, input int ncyc, input int ev, input int ee,
                     input int ev2, input int ee2);
    int cv, ce, cv2, ce2, lat;
    cv = 0; ce = 0; cv2 = 0; ce2 = 0; lat = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (a_valid) cv++;
      if (a_err)   ce++;
      if (b_valid) cv2++;
      if (b_err)   ce2++;
      if (lat < 0 && (a_valid || a_err)) lat = i;
    end
    chk({tag, ".valid"},    cv,  ev);
    chk({tag, ".err"},      ce,  ee);
    chk({tag, ".nf_valid"}, cv2, ev2);
    chk({tag, ".nf_err"},   ce2, ee2);
    if (ev + ee > 0) chk({tag, ".latency"}, lat, 3);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] op, input logic [47:0] mac,
                         input logic [31:0] ip);
    chk({tag, ".opcode"}, a_op,  op);
    chk({tag, ".mac"},    a_mac, mac);
    chk({tag, ".ip"},     a_ip,  ip);
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LMAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] LIP   = 32'hC0A8_0003;
  localparam logic [47:0] SHA1  = 48'h00_0a_35_01_fe_c0;
  localparam logic [31:0] SPA1  = 32'hC0A8_0002;
  localparam logic [47:0] SHA2  = 48'h00_0a_35_01_fe_c1;
  localparam logic [31:0] SPA2  = 32'hC0A8_0005;

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dv = 1'b0; er = 1'b0; data = 8'h00;
    local_mac = LMAC; local_ip = LIP;
    repeat (3) @(negedge clk);
    chk("reset.valid", a_valid, 0);
    chk("reset.err",   a_err,   0);
    chk_out("reset", 16'h0, 48'h0, 32'h0);
    chk("reset.nf_valid", b_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    build(BCAST, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 18, 1'b0);
    send(7, -1, -1); obs("req", 14, 1, 0, 1, 0);
    chk_out("req", 16'h0001, SHA1, SPA1);

    build(BCAST, 16'h0806, 16'h0001, SHA2, SPA2, 32'hC0A8_0004, 18, 1'b0);
    send(7, -1, -1); obs("other_ip", 14, 0, 0, 0, 0);
    chk_out("other_ip", 16'h0001, SHA1, SPA1);

    build(BCAST, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 18, 1'b1);
    send(7, -1, -1); obs("bad_fcs", 14, 0, 1, 1, 0);
    chk_out("bad_fcs", 16'h0001, SHA1, SPA1);

    build(BCAST, 16'h0800, 16'h0001, SHA1, SPA1, LIP, 18, 1'b0);
    send(7, -1, -1); obs("ipv4", 11, 0, 0, 0, 0);
    build(LMAC, 16'h0806, 16'h0002, SHA2, SPA2, LIP, 18, 1'b0);
    send(7, -1, -1); obs("reply", 14, 1, 0, 1, 0);
    chk_out("reply", 16'h0002, SHA2, SPA2);

    build(BCAST, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 18, 1'b0);
    send(7, 45, -1); obs("er_pad", 14, 0, 1, 0, 1);
    send(7, 23, -1); obs("er_sha", 14, 0, 0, 0, 0);
    chk_out("er_sha", 16'h0002, SHA2, SPA2);

    build(BCAST, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 17, 1'b0);
    send(7, -1, -1); obs("len63", 14, 0, 1, 0, 1);

    build(BCAST, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 19, 1'b0);
    send(7, -1, -1); obs("len65", 14, 1, 0, 0, 0);
    chk_out("len65", 16'h0001, SHA1, SPA1);

    build(BCAST, 16'h0806, 16'h0002, SHA2, SPA2, LIP, 18, 1'b0);
    send(8, -1, -1); obs("pre8", 14, 0, 0, 0, 0);
    send(1, -1, -1); obs("pre1", 14, 1, 0, 1, 0);
    chk_out("pre1", 16'h0002, SHA2, SPA2);

    build(48'h02_11_22_33_44_56, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 18, 1'b0);
    send(7, -1, -1); obs("other_mac", 14, 0, 0, 0, 0);

    build(BCAST, 16'h0806, 16'h0001, SHA1, SPA1, LIP, 18, 1'b0);
    send(7, -1, 20); obs("mid_rst", 14, 0, 0, 0, 0);
    chk_out("mid_rst", 16'h0, 48'h0, 32'h0);
    send(7, -1, -1); obs("after_rst", 14, 1, 0, 1, 0);
    chk_out("after_rst", 16'h0001, SHA1, SPA1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
